temp_poll_sched: RTL and testbench
==================================

Name: temp_poll_sched

Overview:
- Sequencer for the I2C temperature-read engine.
- Issues periodic or on-demand read transactions to the engine through a req/ack/done handshake, with timeout, bounded retry and backoff.
- Converts the returned 2-byte register value to a signed 9-bit temperature with 0.5 °C LSB.
- Maintains an over-temperature alarm with hysteresis. Sits between the system and the bus engine; it is the engine's only requester.

Parameters:
- PERIOD_CYC, default 160000: clk cycles between automatic sample requests.
- TIMEOUT_CYC, default 4096: maximum clk cycles in WAIT before the transaction is declared failed.
- MAX_RETRY, default 3: failed attempts per sample before err asserts.
- BACKOFF_CYC, default 16: idle cycles between a failed attempt and the retry.
- T_OS, default 9'sd160: alarm set threshold (80.0 °C, signed, 0.5 °C units).
- T_HYST, default 9'sd150: alarm clear threshold (75.0 °C); T_HYST <= T_OS is required.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: enables periodic polling and trig.
- trig, in, 1: single-cycle on-demand sample request.
- req, out, 1: transaction request to the engine.
- ack, in, 1: engine accepted req (1-cycle pulse).
- done, in, 1: engine finished the transaction (1-cycle pulse).
- nack, in, 1: qualifies done; 1 means the slave did not acknowledge or a bus error occurred.
- rd_data, in, 16: {MSB byte, LSB byte}; valid with done.
- temp, out, 9: signed temperature, 0.5 °C LSB.
- temp_valid, out, 1: 1-cycle pulse when temp updates.
- alarm, out, 1: over-temperature flag.
- err, out, 1: retry budget exhausted on the most recent sample.
- sample_cnt, out, 16: count of successful samples.

Behaviour:
- Reset (async, rst_n=0): all outputs 0. State IDLE; period, timeout, backoff and retry counters 0; pending 0. A reset mid-transaction drops req immediately, and any later done/ack is ignored in IDLE.
- Period counter: counts while enable=1. At PERIOD_CYC-1 it wraps to 0 and sets pending. Held at 0 while enable=0.
- trig=1 with enable=1 sets pending. trig is ignored when enable=0. A trig coinciding with a period wrap, or arriving while pending is already set, yields exactly one pending request.
- IDLE:
  - If pending=1, go to REQ and clear pending.
  - retry_cnt is 0 on every entry to IDLE.
- REQ:
  - req=1, held until ack=1.
  - On ack, req deasserts in the next cycle and the state moves to WAIT with the timeout counter at 0.
- WAIT:
  - Timeout counter increments each cycle.
  - done=1, nack=0 → CAPTURE.
  - done=1, nack=1, or counter reaching TIMEOUT_CYC-1 → FAIL.
  - If done and timeout occur in the same cycle, done wins.
- CAPTURE (1 cycle):
  - temp <= {rd_data[15:8], rd_data[7]}, taken from the rd_data latched at done; rd_data[6:0] is discarded.
  - temp_valid=1 for this one cycle, which is the cycle after done.
  - sample_cnt increments and wraps 0xFFFF→0x0000.
  - err clears.
  - Alarm update on the new temp: set if temp >= T_OS (signed compare); clear if temp < T_HYST; otherwise hold.
  - Next state IDLE.
- FAIL (1 cycle):
  - retry_cnt increments.
  - If the new retry_cnt equals MAX_RETRY: err=1, temp and alarm unchanged, go to IDLE.
  - Otherwise go to BACKOFF.
- BACKOFF: wait BACKOFF_CYC cycles, then go to REQ.
- Pending set during REQ, WAIT, CAPTURE, FAIL or BACKOFF is kept and serviced on the next IDLE. At most one request is queued.
- enable deasserting mid-transaction does not abort it: REQ/WAIT/retry complete normally, but no new period ticks are generated. A pending already set before enable fell is still serviced.
- ack outside REQ and done outside WAIT are ignored.
- Only one transaction is ever outstanding; req never reasserts before done or timeout of the previous attempt.

Test Plan:
- Periodic sample: PERIOD_CYC=100, enable=1, engine acks after 2 cycles and returns done with rd_data=0x1980, nack=0 → temp=9'd51 (25.5 °C), temp_valid pulses once per 100-cycle period, sample_cnt counts 1,2,3.
- Negative value and alarm hysteresis: rd_data sequence 0xE700, 0x5000, 0x4C00, 0x4A80 → temp -50, 160, 152, 149; alarm 0, 1, 1, 0.
- Retry/timeout: engine never asserts done, TIMEOUT_CYC=32 → 3 attempts, each separated by 16 backoff cycles; err=1 after the third; temp unchanged. A subsequent good sample clears err.
- NACK then success: first done has nack=1, second done has nack=0 with rd_data=0x0080 → one backoff, then temp=1, err=0.
- Coincident triggers: trig asserted in the same cycle as the period wrap, and again during WAIT → exactly 2 transactions total, no overlapping req.
- Reset mid-WAIT: rst_n pulsed low while in WAIT, then a stray done arrives → all outputs 0, no temp_valid, state IDLE.

Source files
------------

// File: rtl/temp_poll_sched.sv
// temp_poll_sched: sequences read transactions to the I2C temperature engine.
// Periodic or on-demand requests go out over a req/ack/done handshake with a
// per-attempt timeout, bounded retries separated by a backoff gap, and the
// returned register is converted to a signed 0.5 degC temperature feeding an
// over-temperature alarm with hysteresis.
module temp_poll_sched #(
    parameter int unsigned       PERIOD_CYC  = 160000,
    parameter int unsigned       TIMEOUT_CYC = 4096,
    parameter int unsigned       MAX_RETRY   = 3,
    parameter int unsigned       BACKOFF_CYC = 16,
    parameter logic signed [8:0] T_OS        = 9'sd160,
    parameter logic signed [8:0] T_HYST      = 9'sd150
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        trig,
    output logic        req,
    input  logic        ack,
    input  logic        done,
    input  logic        nack,
    input  logic [15:0] rd_data,
    output logic [8:0]  temp,
    output logic        temp_valid,
    output logic        alarm,
    output logic        err,
    output logic [15:0] sample_cnt
);

    localparam int unsigned PW = (PERIOD_CYC  > 1) ? $clog2(PERIOD_CYC)  : 1;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned BW = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);

    localparam logic [PW-1:0] PERIOD_LAST  = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BACKOFF_LAST = BW'(BACKOFF_CYC - 1);
    localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CAPTURE,
        S_FAIL,
        S_BACKOFF
    } state_e;

    state_e            state_q,      state_d;
    logic [PW-1:0]     period_q,     period_d;
    logic [TW-1:0]     timeout_q,    timeout_d;
    logic [BW-1:0]     backoff_q,    backoff_d;
    logic [RW-1:0]     retry_q,      retry_d;
    logic              pending_q,    pending_d;
    logic              req_q,        req_d;
    logic [8:0]        temp_q,       temp_d;
    logic              temp_valid_q, temp_valid_d;
    logic              alarm_q,      alarm_d;
    logic              err_q,        err_d;
    logic [15:0]       sample_cnt_q, sample_cnt_d;

    logic              period_tick;
    logic              set_pending;
    logic [RW-1:0]     retry_inc;
    logic signed [8:0] temp_new;
    logic              rd_lsb_unused;

    // Register value {MSB, LSB}: integer degrees in the MSB, half degree in LSB bit 7.
    always_comb begin
        temp_new      = {rd_data[15:8], rd_data[7]};
        rd_lsb_unused = ^rd_data[6:0];
    end

    // Next-state logic: period timer, request queue and transaction sequencing.
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        timeout_d    = timeout_q;
        backoff_d    = backoff_q;
        retry_d      = retry_q;
        req_d        = req_q;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        alarm_d      = alarm_q;
        err_d        = err_q;
        sample_cnt_d = sample_cnt_q;
        period_tick  = 1'b0;
        retry_inc    = retry_q + RW'(1);

        if (!enable) begin
            period_d = '0;
        end else if (period_q == PERIOD_LAST) begin
            period_d    = '0;
            period_tick = 1'b1;
        end else begin
            period_d = period_q + PW'(1);
        end

        // A single flag: coincident or repeated requests collapse into one.
        set_pending = period_tick | (enable & trig);
        pending_d   = pending_q | set_pending;

        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                req_d   = 1'b0;
                if (pending_q) begin
                    state_d   = S_REQ;
                    req_d     = 1'b1;
                    pending_d = set_pending;
                end
            end

            S_REQ: begin
                req_d = 1'b1;
                if (ack) begin
                    req_d     = 1'b0;
                    timeout_d = '0;
                    state_d   = S_WAIT;
                end
            end

            S_WAIT: begin
                timeout_d = timeout_q + TW'(1);
                if (done) begin
                    if (!nack) begin
                        // Result registers load on the done edge so temp,
                        // temp_valid, alarm and sample_cnt are all visible
                        // together in the CAPTURE cycle.
                        temp_d       = temp_new;
                        temp_valid_d = 1'b1;
                        sample_cnt_d = sample_cnt_q + 16'd1;
                        err_d        = 1'b0;
                        if (temp_new >= T_OS) begin
                            alarm_d = 1'b1;
                        end else if (temp_new < T_HYST) begin
                            alarm_d = 1'b0;
                        end
                        state_d = S_CAPTURE;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (timeout_q == TIMEOUT_LAST) begin
                    state_d = S_FAIL;
                end
            end

            S_CAPTURE: begin
                retry_d = '0;
                state_d = S_IDLE;
            end

            S_FAIL: begin
                if (retry_inc == RETRY_LIMIT) begin
                    err_d   = 1'b1;
                    retry_d = '0;
                    state_d = S_IDLE;
                end else begin
                    retry_d   = retry_inc;
                    backoff_d = '0;
                    if (BACKOFF_CYC == 0) begin
                        req_d   = 1'b1;
                        state_d = S_REQ;
                    end else begin
                        state_d = S_BACKOFF;
                    end
                end
            end

            S_BACKOFF: begin
                backoff_d = backoff_q + BW'(1);
                if (backoff_q == BACKOFF_LAST) begin
                    backoff_d = '0;
                    req_d     = 1'b1;
                    state_d   = S_REQ;
                end
            end

            default: begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything and drops req at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            period_q     <= '0;
            timeout_q    <= '0;
            backoff_q    <= '0;
            retry_q      <= '0;
            pending_q    <= 1'b0;
            req_q        <= 1'b0;
            temp_q       <= '0;
            temp_valid_q <= 1'b0;
            alarm_q      <= 1'b0;
            err_q        <= 1'b0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            timeout_q    <= timeout_d;
            backoff_q    <= backoff_d;
            retry_q      <= retry_d;
            pending_q    <= pending_d;
            req_q        <= req_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            alarm_q      <= alarm_d;
            err_q        <= err_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign req        = req_q;
    assign temp       = temp_q;
    assign temp_valid = temp_valid_q;
    assign alarm      = alarm_q;
    assign err        = err_q;
    assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_temp_poll_sched.sv
// tb_temp_poll_sched: directed bench for temp_poll_sched with a behavioural
// engine model, a conversion/alarm vector table driven by periodic polling,
// and hand-written retry, NACK, coincident-trigger and reset sequences.
module tb_temp_poll_sched;

    localparam int ACK_DLY = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        trig = 1'b0;
    logic        req;
    logic        ack;
    logic        done;
    logic        nack;
    logic [15:0] rd_data;
    logic [8:0]  temp;
    logic        temp_valid;
    logic        alarm;
    logic        err;
    logic [15:0] sample_cnt;

    // Engine model drive and controls
    logic        eng_ack = 1'b0;
    logic        eng_done = 1'b0;
    logic        eng_nack = 1'b0;
    logic [15:0] eng_rd = '0;
    logic        man_ack = 1'b0;
    logic        man_done = 1'b0;
    logic [15:0] man_rd = '0;
    logic        eng_auto = 1'b0;
    logic        eng_silent = 1'b0;
    logic [15:0] eng_data = '0;
    int          done_dly = 2;
    int          nack_until = 0;
    int          eng_done_cnt = 0;
    int          n_overlap = 0;

    // Monitors
    int          cyc = 0;
    int          rise_q[$];
    logic        req_prev = 1'b0;
    int          n_tv = 0;

    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [15:0] rd;
        int          temp;
        int          alarm;
    } vec_t;

    vec_t vecs [12];

    assign ack     = eng_ack | man_ack;
    assign done    = eng_done | man_done;
    assign nack    = eng_nack;
    assign rd_data = eng_rd | man_rd;

    temp_poll_sched #(
        .PERIOD_CYC  (100),
        .TIMEOUT_CYC (32),
        .MAX_RETRY   (3),
        .BACKOFF_CYC (16),
        .T_OS        (9'sd160),
        .T_HYST      (9'sd150)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .trig       (trig),
        .req        (req),
        .ack        (ack),
        .done       (done),
        .nack       (nack),
        .rd_data    (rd_data),
        .temp       (temp),
        .temp_valid (temp_valid),
        .alarm      (alarm),
        .err        (err),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (req && !req_prev) rise_q.push_back(cyc);
        req_prev <= req;
        if (temp_valid) n_tv <= n_tv + 1;
    end

    // Engine: ack ACK_DLY cycles after seeing req, then done after done_dly
    // cycles (unless silent); counts any req seen while a transaction is open.
    initial begin
        forever begin
            @(negedge clk);
            if (eng_auto && req) begin
                repeat (ACK_DLY) @(negedge clk);
                eng_ack = 1'b1;
                @(negedge clk);
                eng_ack = 1'b0;
                if (!eng_silent) begin
                    repeat (done_dly - 1) begin
                        if (req) n_overlap++;
                        @(negedge clk);
                    end
                    if (req) n_overlap++;
                    eng_done = 1'b1;
                    eng_rd   = eng_data;
                    eng_nack = (eng_done_cnt < nack_until);
                    eng_done_cnt++;
                    @(negedge clk);
                    eng_done = 1'b0;
                    eng_nack = 1'b0;
                    eng_rd   = '0;
                end
            end
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic one_shot();
        @(negedge clk);
        enable = 1'b1;
        trig   = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        trig   = 1'b0;
    endtask

    task automatic wait_tv(input int bound, output int ok);
        ok = 0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (temp_valid) begin
                ok = 1;
                break;
            end
        end
    endtask

    function automatic int stemp();
        return int'($signed(temp));
    endfunction

    initial begin
        int ok;
        int b;
        int tvb;
        int ovb;
        int c0;
        int tv_cyc;
        int prev_cyc;

        // {rd_data, temp (0.5 degC), alarm after update}
        vecs[0]  = '{16'h1980,   51, 0};
        vecs[1]  = '{16'hE700,  -50, 0};
        vecs[2]  = '{16'h5000,  160, 1};
        vecs[3]  = '{16'h4C00,  152, 1};
        vecs[4]  = '{16'h4A80,  149, 0};
        vecs[5]  = '{16'h4B00,  150, 0};
        vecs[6]  = '{16'h4F80,  159, 0};
        vecs[7]  = '{16'h5000,  160, 1};
        vecs[8]  = '{16'h4B00,  150, 1};
        vecs[9]  = '{16'h7F80,  255, 1};
        vecs[10] = '{16'h0080,    1, 0};
        vecs[11] = '{16'h8000, -256, 0};

        // Reset state
        idle(3);
        check("rst_req", req, 0);
        check("rst_temp", temp, 0);
        check("rst_tv", temp_valid, 0);
        check("rst_alarm", alarm, 0);
        check("rst_err", err, 0);
        check("rst_cnt", sample_cnt, 0);
        rst_n = 1'b1;
        idle(2);

        // Periodic polling through the conversion/alarm table
        eng_auto = 1'b1;
        eng_data = vecs[0].rd;
        prev_cyc = 0;
        @(negedge clk);
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wait_tv(250, ok);
            check($sformatf("vec%0d_tv_seen", i), ok, 1);
            tv_cyc = cyc;
            check($sformatf("vec%0d_temp", i), stemp(), vecs[i].temp);
            check($sformatf("vec%0d_alarm", i), alarm, vecs[i].alarm);
            check($sformatf("vec%0d_cnt", i), sample_cnt, i + 1);
            check($sformatf("vec%0d_err", i), err, 0);
            if (i > 0) check($sformatf("vec%0d_period", i), tv_cyc - prev_cyc, 100);
            prev_cyc = tv_cyc;
            if (i < 11) eng_data = vecs[i + 1].rd;
        end
        enable = 1'b0;
        idle(20);

        // Timeout retries: 3 attempts spaced 3 REQ + 32 WAIT + 1 FAIL + 16 BACKOFF
        eng_silent = 1'b1;
        b   = rise_q.size();
        tvb = n_tv;
        one_shot();
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (err) begin
                ok = 1;
                break;
            end
        end
        check("retry_err_set", ok, 1);
        check("retry_attempts", rise_q.size() - b, 3);
        if (rise_q.size() >= b + 3) begin
            check("retry_gap1", rise_q[b + 1] - rise_q[b], 52);
            check("retry_gap2", rise_q[b + 2] - rise_q[b + 1], 52);
        end
        check("retry_temp_kept", stemp(), -256);
        check("retry_cnt_kept", sample_cnt, 12);
        check("retry_no_tv", n_tv - tvb, 0);
        idle(80);
        check("retry_no_more_req", rise_q.size() - b, 3);
        check("retry_err_held", err, 1);

        eng_silent = 1'b0;
        eng_data   = 16'h1980;
        one_shot();
        wait_tv(100, ok);
        check("recover_tv_seen", ok, 1);
        check("recover_temp", stemp(), 51);
        check("recover_err", err, 0);
        check("recover_cnt", sample_cnt, 13);
        idle(5);

        // NACK then success: one backoff, spacing 3 REQ + 2 WAIT + 1 FAIL + 16 BACKOFF
        nack_until = eng_done_cnt + 1;
        eng_data   = 16'h0080;
        b = rise_q.size();
        one_shot();
        wait_tv(150, ok);
        check("nack_tv_seen", ok, 1);
        check("nack_temp", stemp(), 1);
        check("nack_err", err, 0);
        check("nack_alarm", alarm, 0);
        check("nack_cnt", sample_cnt, 14);
        check("nack_attempts", rise_q.size() - b, 2);
        if (rise_q.size() >= b + 2) check("nack_gap", rise_q[b + 1] - rise_q[b], 22);
        idle(5);

        // Trig on the period wrap, then again during WAIT
        done_dly = 6;
        b   = rise_q.size();
        tvb = n_tv;
        ovb = n_overlap;
        @(negedge clk);
        enable = 1'b1;
        c0 = cyc;
        repeat (99) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        repeat (5) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig   = 1'b0;
        enable = 1'b0;
        idle(80);
        check("coin_xacts", rise_q.size() - b, 2);
        check("coin_tv", n_tv - tvb, 2);
        check("coin_overlap", n_overlap - ovb, 0);
        check("coin_cnt", sample_cnt, 16);
        if (rise_q.size() >= b + 2) begin
            check("coin_first_req", rise_q[b] - c0, 101);
            check("coin_second_req", rise_q[b + 1] - rise_q[b], 11);
        end

        // Reset mid-WAIT, then a stray done
        eng_auto = 1'b0;
        idle(3);
        b = rise_q.size();
        one_shot();
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req) begin
                ok = 1;
                break;
            end
        end
        check("rw_req_seen", ok, 1);
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        idle(2);
        rst_n = 1'b0;
        #1;
        check("rw_rst_req", req, 0);
        check("rw_rst_temp", temp, 0);
        check("rw_rst_cnt", sample_cnt, 0);
        check("rw_rst_tv", temp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tvb = n_tv;
        @(negedge clk);
        man_done = 1'b1;
        man_rd   = 16'h5000;
        @(negedge clk);
        man_done = 1'b0;
        man_rd   = '0;
        idle(10);
        check("rw_stray_tv", n_tv - tvb, 0);
        check("rw_stray_temp", temp, 0);
        check("rw_stray_cnt", sample_cnt, 0);
        check("rw_stray_alarm", alarm, 0);
        check("rw_stray_err", err, 0);
        check("rw_no_new_req", rise_q.size() - b, 1);

        // Reset while req is high drops it without waiting for a clock
        one_shot();
        ok = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req) begin
                ok = 1;
                break;
            end
        end
        check("rq_req_seen", ok, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rq_req_dropped", req, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        check("rq_req_stays_low", req, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "bench time limit reached");
    end

endmodule
